// File: rtl/trig_pkg.sv
// Shared constants and types for the trigonometric expansion sequencer:
// phase/table widths, quadrant codes, magnitude limits and the FSM states.
package trig_pkg;

  localparam int PHASE_W   = 8;
  localparam int LUT_IDX_W = 7;
  localparam int MAG_W     = 16;

  // Quadrant of an 8-bit phase, taken from phase[7:6].
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  localparam logic [MAG_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [MAG_W-1:0] ONE_MAG = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A table magnitude of exactly 1.0 cannot be represented in signed Q1.15.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (m == ONE_MAG) ? SAT_POS : m;
  endfunction

  // Two's complement sign application on an already-saturated magnitude.
  function automatic logic [MAG_W-1:0] apply_sign(input logic [MAG_W-1:0] m,
                                                  input logic neg);
    return neg ? (~m + 16'd1) : m;
  endfunction

endpackage

// File: rtl/trig_expansion_seq_if.sv
// Sample-in / term-pair-out bus of the expansion sequencer.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its payload stable until that edge; ready may
// depend on nothing from the same side's valid (no combinational loop).
// master = sample producer / term consumer, slave = the sequencer.
interface trig_expansion_seq_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        x_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sin;
  logic [DATA_W-1:0] out_cos;
  logic [2:0]        out_p;
  logic              out_last;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, out_sin, out_cos, out_p, out_last
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, out_sin, out_cos, out_p, out_last
  );
endinterface

// File: rtl/trig_quadrant_fold.sv
// Maps an 8-bit phase (256 codes = 2*pi) onto the quarter-wave table and
// rebuilds signed Q1.15 sin/cos by quadrant swap, sign and saturation.
module trig_quadrant_fold
  import trig_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  output logic [MAG_W-1:0]   sin_term,
  output logic [MAG_W-1:0]   cos_term
);

  logic [LUT_IDX_W-1:0] idx;
  logic [MAG_W-1:0]     s_mag;
  logic [MAG_W-1:0]     c_mag;
  quad_t                quad;

  assign idx  = {1'b0, phase[5:0]};
  assign quad = quad_t'(phase[7:6]);

  trig_qw_lut u_lut (
    .idx     (idx),
    .sin_mag (s_mag),
    .cos_mag (c_mag)
  );

  // Quadrant folding: pick swapped/negated table outputs per quadrant.
  always_comb begin
    sin_term = '0;
    cos_term = '0;
    case (quad)
      Q0: begin
        sin_term = apply_sign(sat_mag(s_mag), 1'b0);
        cos_term = apply_sign(sat_mag(c_mag), 1'b0);
      end
      Q1: begin
        sin_term = apply_sign(sat_mag(c_mag), 1'b0);
        cos_term = apply_sign(sat_mag(s_mag), 1'b1);
      end
      Q2: begin
        sin_term = apply_sign(sat_mag(s_mag), 1'b1);
        cos_term = apply_sign(sat_mag(c_mag), 1'b1);
      end
      Q3: begin
        sin_term = apply_sign(sat_mag(c_mag), 1'b1);
        cos_term = apply_sign(sat_mag(s_mag), 1'b0);
      end
      default: begin
        sin_term = '0;
        cos_term = '0;
      end
    endcase
  end

endmodule

// File: rtl/trig_qw_lut.sv
// Quarter-wave sine table: 65 entries covering 0..pi/2 in pi/128 steps,
// unsigned magnitude with 0x8000 = 1.0. Cosine reads the mirrored entry.
module trig_qw_lut
  import trig_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [MAG_W-1:0]     sin_mag,
  output logic [MAG_W-1:0]     cos_mag
);

  function automatic logic [MAG_W-1:0] qw_sin(input logic [LUT_IDX_W-1:0] i);
    logic [MAG_W-1:0] v;
    v = '0;
    case (i)
      7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;
      7'd3:  v = 16'd2411;  7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;
      7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;  7'd8:  v = 16'd6393;
      7'd9:  v = 16'd7180;  7'd10: v = 16'd7962;  7'd11: v = 16'd8740;
      7'd12: v = 16'd9512;  7'd13: v = 16'd10279; 7'd14: v = 16'd11039;
      7'd15: v = 16'd11793; 7'd16: v = 16'd12540; 7'd17: v = 16'd13279;
      7'd18: v = 16'd14010; 7'd19: v = 16'd14733; 7'd20: v = 16'd15447;
      7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17531;
      7'd24: v = 16'd18205; 7'd25: v = 16'd18868; 7'd26: v = 16'd19520;
      7'd27: v = 16'd20160; 7'd28: v = 16'd20788; 7'd29: v = 16'd21403;
      7'd30: v = 16'd22006; 7'd31: v = 16'd22595; 7'd32: v = 16'd23170;
      7'd33: v = 16'd23732; 7'd34: v = 16'd24279; 7'd35: v = 16'd24812;
      7'd36: v = 16'd25330; 7'd37: v = 16'd25833; 7'd38: v = 16'd26320;
      7'd39: v = 16'd26791; 7'd40: v = 16'd27246; 7'd41: v = 16'd27684;
      7'd42: v = 16'd28106; 7'd43: v = 16'd28511; 7'd44: v = 16'd28899;
      7'd45: v = 16'd29269; 7'd46: v = 16'd29622; 7'd47: v = 16'd29957;
      7'd48: v = 16'd30274; 7'd49: v = 16'd30572; 7'd50: v = 16'd30853;
      7'd51: v = 16'd31114; 7'd52: v = 16'd31357; 7'd53: v = 16'd31581;
      7'd54: v = 16'd31786; 7'd55: v = 16'd31972; 7'd56: v = 16'd32138;
      7'd57: v = 16'd32286; 7'd58: v = 16'd32413; 7'd59: v = 16'd32522;
      7'd60: v = 16'd32610; 7'd61: v = 16'd32679; 7'd62: v = 16'd32729;
      7'd63: v = 16'd32758; 7'd64: v = 16'd32768;
      default: v = '0;
    endcase
    return v;
  endfunction

  // cos(r) = sin(pi/2 - r): entry 64 - idx of the same table.
  always_comb begin
    sin_mag = qw_sin(idx);
    cos_mag = qw_sin(7'd64 - idx);
  end

endmodule

// File: rtl/trig_expansion_seq.sv
// Functional-link expansion sequencer: accepts one sample x and streams the
// pairs sin(p*pi*x), cos(p*pi*x) for p = 1..ORDER, one table lookup per
// harmonic, through a single output register under valid/ready backpressure.
module trig_expansion_seq
  import trig_pkg::*;
#(
  parameter int ORDER  = 3,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trig_expansion_seq_if.slave  bus,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam logic [2:0] P_LAST = 3'(ORDER);

  state_t              state;
  logic [PHASE_W-1:0]  x_reg;
  logic [PHASE_W-1:0]  phase_acc;
  logic [2:0]          p_cnt;

  logic                out_valid_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   out_sin_q;
  logic [DATA_W-1:0]   out_cos_q;
  logic [2:0]          out_p_q;

  logic [MAG_W-1:0]    fold_sin;
  logic [MAG_W-1:0]    fold_cos;
  logic                issue;

  trig_quadrant_fold u_fold (
    .phase    (phase_acc),
    .sin_term (fold_sin),
    .cos_term (fold_cos)
  );

  // A new pair may be issued only into an empty or draining output register,
  // so a stalled consumer freezes both the phase and the harmonic count.
  assign issue = (state == RUN) && (!out_valid_q || bus.out_ready);

  // FSM, phase accumulator, harmonic counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_reg       <= '0;
      phase_acc   <= '0;
      p_cnt       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sin_q   <= '0;
      out_cos_q   <= '0;
      out_p_q     <= '0;
    end else begin
      // Consumed pair leaves the register unless an issue below refills it.
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg     <= bus.x_in;
            phase_acc <= bus.x_in;
            p_cnt     <= 3'd1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            out_valid_q <= 1'b1;
            out_sin_q   <= fold_sin;
            out_cos_q   <= fold_cos;
            out_p_q     <= p_cnt;
            out_last_q  <= (p_cnt == P_LAST);
            phase_acc   <= phase_acc + x_reg;
            p_cnt       <= p_cnt + 3'd1;
            if (p_cnt == P_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sin   = out_sin_q;
  assign bus.out_cos   = out_cos_q;
  assign bus.out_p     = out_p_q;

  assign busy      = (state == RUN) || out_valid_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_trig_expansion_seq.sv
// Bench for trig_expansion_seq: directed cases with known term values plus
// randomized samples and backpressure, checked against a real-math model.
module tb_trig_expansion_seq;
  import trig_pkg::*;

  localparam int ORDER  = 3;
  localparam int DATA_W = 16;
  localparam int W      = 36;  // {p[2:0], last, sin[15:0], cos[15:0]}

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit rand_ready = 1'b0;
  int accept_edge = 0;

  logic [W-1:0] exp_q[$];   // model expectations
  logic [W-1:0] dir_q[$];   // hand-derived expectations for directed cases
  logic [W-1:0] mon_obs;
  logic [W-1:0] mon_exp;

  trig_expansion_seq_if #(.DATA_W(DATA_W)) bus ();

  trig_expansion_seq #(.ORDER(ORDER), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Term = round(32768 * f(2*pi*phase/256)) in magnitude, capped at 0x7FFF.
  function automatic logic [15:0] ref_term(input int ph, input bit is_cos);
    real ang;
    real v;
    real mag;
    int  m;
    ang = 2.0 * 3.14159265358979323846 * real'(ph) / 256.0;
    v   = is_cos ? $cos(ang) : $sin(ang);
    mag = ((v < 0.0) ? -v : v) * 32768.0;
    m   = $rtoi(mag + 0.5);
    if (m > 32767) m = 32767;
    return (v < 0.0) ? 16'(-m) : 16'(m);
  endfunction

  task automatic model_push(input logic [7:0] x);
    int ph;
    for (int p = 1; p <= ORDER; p++) begin
      ph = (p * int'(x)) % 256;
      exp_q.push_back({3'(p), 1'(p == ORDER), ref_term(ph, 1'b0), ref_term(ph, 1'b1)});
    end
  endtask

  task automatic expect_spec(input logic [15:0] s1, input logic [15:0] c1,
                             input logic [15:0] s2, input logic [15:0] c2,
                             input logic [15:0] s3, input logic [15:0] c3);
    dir_q.push_back({3'd1, 1'b0, s1, c1});
    dir_q.push_back({3'd2, 1'b0, s2, c2});
    dir_q.push_back({3'd3, 1'b1, s3, c3});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        model_push(bus.x_in);
        accept_edge = cyc + 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        mon_obs = {bus.out_p, bus.out_last, bus.out_sin, bus.out_cos};
        check("pair_expected", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("model_pair", mon_obs, mon_exp);
        end
        if (dir_q.size() != 0) begin
          mon_exp = dir_q.pop_front();
          check("spec_pair", mon_obs, mon_exp);
        end
      end
    end
  end

  // Randomized consumer readiness.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [7:0] x);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    while (!done && n < 100) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      n++;
    end
    check("accept_in_time", W'(done), W'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x_in     = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dir_q.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drained", W'(exp_q.size() == 0 && dir_q.size() == 0 && !busy), W'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a_edge;
    int b_edge;
    int n;
    bus.in_valid  = 1'b0;
    bus.x_in      = 8'h00;
    bus.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_last",  W'(bus.out_last), W'(0));
    check("rst_terms",     W'({bus.out_sin, bus.out_cos}), W'(0));
    check("rst_out_p",     W'(bus.out_p), W'(0));
    check("rst_busy",      W'(busy), W'(0));
    check("rst_state",     W'(dbg_state), W'(IDLE));

    // x = 0: sin 0, cos +1 (saturated) for every harmonic; first-pair latency.
    expect_spec(16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF);
    send_sample(8'h00);
    @(negedge clk);
    check("lat_not_yet", W'(bus.out_valid), W'(0));
    @(negedge clk);
    check("lat_p1", W'({bus.out_valid, bus.out_p}), W'({1'b1, 3'd1}));
    check("lat_edge", W'(cyc - accept_edge), W'(1));
    wait_drain();

    // Quadrant boundaries and the small-angle table entries.
    expect_spec(16'h7FFF, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h0000);
    send_sample(8'h40);
    wait_drain();
    expect_spec(16'h0324, 16'h7FF6, 16'h0648, 16'h7FD9, 16'h096B, 16'h7FA7);
    send_sample(8'h01);
    wait_drain();
    expect_spec(16'h0000, 16'h8001, 16'h0000, 16'h7FFF, 16'h0000, 16'h8001);
    send_sample(8'h80);
    wait_drain();

    // Backpressure for four cycles while pair p = 2 is presented.
    expect_spec(16'h0324, 16'h7FF6, 16'h0648, 16'h7FD9, 16'h096B, 16'h7FA7);
    send_sample(8'h01);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stall_hold", W'({bus.out_valid, bus.out_p, bus.out_sin, bus.out_cos}),
            W'({1'b1, 3'd2, 16'h0648, 16'h7FD9}));
      check("stall_in_ready", W'(bus.in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset pulse in the middle of a sequence discards it.
    send_sample(8'h40);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_state", W'(dbg_state), W'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", W'({bus.out_valid, bus.in_ready}), W'({1'b0, 1'b1}));
    end
    expect_spec(16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF);
    send_sample(8'h00);
    wait_drain();

    // Back-to-back samples with in_valid held high throughout.
    expect_spec(16'h0324, 16'h7FF6, 16'h0648, 16'h7FD9, 16'h096B, 16'h7FA7);
    expect_spec(16'h7FFF, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h0000);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.x_in     = 8'h01;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 50);
    a_edge = cyc + 1;
    @(posedge clk);
    #1;
    bus.x_in = 8'h40;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 50);
    b_edge = cyc + 1;
    check("b2b_gap", W'(b_edge - a_edge), W'(ORDER + 1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_drain();

    // Random samples, random idle gaps, random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_sample(8'($urandom));
    end
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
